// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: opcode/func constants, sel_pc encodings, FSM states and branch-condition helper (package pc_ctrl_pkg)
package pc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  typedef enum logic [1:0] {SEL_PC4, SEL_JMP, SEL_BR, SEL_JR} sel_pc_e;
  typedef enum logic [1:0] {IDLE, DELAY, FLUSH} state_e;
  function automatic logic br_cond(input logic [5:0] op, input logic zf, input logic nf);
    return (op == OP_BEQ  &&  zf) ||
           (op == OP_BNE  && !zf) ||
           (op == OP_BLEZ && (zf || nf)) ||
           (op == OP_BGTZ && !zf && !nf);
  endfunction
endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if: pipeline-side bus of pc_redirect_ctrl; master = pipeline, slave = controller.
// Signals: ID_inst/ID_valid, EXE_inst/EXE_valid, zf, nf, stall in; sel_pc, flush, busy out.
// With REDIRECT_STATS_EN defined, adds br_taken_cnt and jmp_cnt (CNT_W bits).
interface pc_redirect_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0] ID_inst;
  logic        ID_valid;
  logic [31:0] EXE_inst;
  logic        EXE_valid;
  logic        zf;
  logic        nf;
  logic        stall;
  logic [1:0]  sel_pc;
  logic        flush;
  logic        busy;
`ifdef REDIRECT_STATS_EN
  logic [CNT_W-1:0] br_taken_cnt;
  logic [CNT_W-1:0] jmp_cnt;
`endif
  modport master (
    output ID_inst, ID_valid, EXE_inst, EXE_valid, zf, nf, stall,
    input  sel_pc, flush, busy
`ifdef REDIRECT_STATS_EN
    , input br_taken_cnt, jmp_cnt
`endif
  );
  modport slave (
    input  ID_inst, ID_valid, EXE_inst, EXE_valid, zf, nf, stall,
    output sel_pc, flush, busy
`ifdef REDIRECT_STATS_EN
    , output br_taken_cnt, jmp_cnt
`endif
  );
endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones; ports clk, nrst (async active-low), en, count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count_q <= '0;
    else if (en && count_q != '1) count_q <= count_q + W'(1);
  assign count = count_q;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: PC redirect select and IF/ID flush sequencing for EXE branches and ID jumps.
// Ports: clk, nrst (async active-low), bus (pc_redirect_ctrl_if.slave).
// Optional macro REDIRECT_STATS_EN adds saturating br_taken_cnt/jmp_cnt statistics.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 2,
  parameter int J_FLUSH_DELAY   = 1,
  parameter int J_FLUSH_CYCLES  = 1,
  parameter int CNT_W           = 16
) (
  input logic              clk,
  input logic              nrst,
  pc_redirect_ctrl_if.slave bus
);
  if (BR_FLUSH_CYCLES < 1 || BR_FLUSH_CYCLES > 7 || J_FLUSH_DELAY < 0 || J_FLUSH_DELAY > 3 ||
      J_FLUSH_CYCLES < 1 || J_FLUSH_CYCLES > 7 || CNT_W < 4 || CNT_W > 32) begin : g_bad_param
    $error("pc_redirect_ctrl: parameter out of range");
  end
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       flush_q;
  logic       taken, jmp_j, jmp_r, idle, jmp_acc;
  logic       unused_bits;
  assign unused_bits = ^{bus.ID_inst[25:6], bus.EXE_inst[25:0]};
  assign taken   = bus.EXE_valid && br_cond(bus.EXE_inst[31:26], bus.zf, bus.nf);
  assign jmp_j   = bus.ID_valid && (bus.ID_inst[31:26] == OP_J || bus.ID_inst[31:26] == OP_JAL);
  assign jmp_r   = bus.ID_valid && bus.ID_inst[31:26] == OP_RTYPE &&
                   (bus.ID_inst[5:0] == FN_JR || bus.ID_inst[5:0] == FN_JALR);
  assign idle    = state_q == IDLE;
  // Jumps are only acted on from IDLE; a simultaneous taken branch is older and wins.
  assign jmp_acc = idle && (jmp_j || jmp_r) && !taken;
  assign bus.sel_pc = bus.stall     ? SEL_PC4 :
                      taken         ? SEL_BR  :
                      idle && jmp_j ? SEL_JMP :
                      idle && jmp_r ? SEL_JR  : SEL_PC4;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (taken) begin
      state_d = FLUSH;
      cnt_d   = 3'(BR_FLUSH_CYCLES);
    end else if (jmp_acc) begin
      state_d = J_FLUSH_DELAY > 0 ? DELAY : FLUSH;
      cnt_d   = J_FLUSH_DELAY > 0 ? 3'(J_FLUSH_DELAY) : 3'(J_FLUSH_CYCLES);
    end else if (!idle) begin
      state_d = cnt_q != 3'd1 ? state_q : state_q == DELAY ? FLUSH : IDLE;
      cnt_d   = cnt_q != 3'd1 ? cnt_q - 3'd1 : state_q == DELAY ? 3'(J_FLUSH_CYCLES) : 3'd0;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= state_d == FLUSH;
    end
  assign bus.flush = flush_q;
  assign bus.busy  = !idle;
`ifdef REDIRECT_STATS_EN
  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk(clk), .nrst(nrst), .en(taken && !bus.stall), .count(bus.br_taken_cnt)
  );
  sat_counter #(.W(CNT_W)) u_jmp_cnt (
    .clk(clk), .nrst(nrst), .en(jmp_acc && !bus.stall), .count(bus.jmp_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vector table plus reset-abort and statistics sequences for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BEQ  = 32'h1000_0000;
  localparam logic [31:0] BNE  = 32'h1400_0000;
  localparam logic [31:0] BLEZ = 32'h1800_0000;
  localparam logic [31:0] BGTZ = 32'h1C00_0000;
  localparam logic [31:0] J    = 32'h0800_0040;
  localparam logic [31:0] JAL  = 32'h0C00_0080;
  localparam logic [31:0] JR   = 32'h03E0_0008;
  localparam logic [31:0] JALR = 32'h0200_F809;
  typedef struct {
    logic [31:0] id_inst;
    logic        id_v;
    logic [31:0] exe_inst;
    logic        exe_v, zf, nf, st;
    logic [1:0]  sel;
    logic        fl, bz;
  } vec_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic nrst3 = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t tv[44];
  always #5 clk = ~clk;
  pc_redirect_ctrl_if #(.CNT_W(16)) bus ();
  pc_redirect_ctrl_if #(.CNT_W(4))  bus3 ();
  pc_redirect_ctrl #(.CNT_W(16)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  pc_redirect_ctrl #(.BR_FLUSH_CYCLES(3), .CNT_W(4)) dut3 (.clk(clk), .nrst(nrst3), .bus(bus3));
  function automatic vec_t v(input logic [31:0] id, input logic idv, input logic [31:0] ex,
                             input logic exv, input logic zf, input logic nf, input logic st,
                             input logic [1:0] sel, input logic fl, input logic bz);
    vec_t r;
    r.id_inst = id; r.id_v = idv; r.exe_inst = ex; r.exe_v = exv;
    r.zf = zf; r.nf = nf; r.st = st; r.sel = sel; r.fl = fl; r.bz = bz;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t r);
    bus.ID_inst = r.id_inst; bus.ID_valid = r.id_v; bus.EXE_inst = r.exe_inst;
    bus.EXE_valid = r.exe_v; bus.zf = r.zf; bus.nf = r.nf; bus.stall = r.st;
  endtask
  task automatic drive3(input logic [31:0] ex, input logic exv, input logic zf);
    bus3.ID_inst = NOP; bus3.ID_valid = 1'b0; bus3.EXE_inst = ex; bus3.EXE_valid = exv;
    bus3.zf = zf; bus3.nf = 1'b0; bus3.stall = 1'b0;
  endtask
  initial begin
    int exp_cnt;
    tv[0]  = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[1]  = v(NOP,  0, BEQ,  1, 0, 0, 0, 0, 0, 0);
    tv[2]  = v(NOP,  0, BEQ,  0, 1, 0, 0, 0, 0, 0);
    tv[3]  = v(NOP,  0, BEQ,  1, 1, 0, 0, 2, 0, 0);
    tv[4]  = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[5]  = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[6]  = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[7]  = v(JR,   1, NOP,  0, 0, 0, 0, 3, 0, 0);
    tv[8]  = v(JAL,  1, NOP,  0, 0, 0, 0, 0, 0, 1);
    tv[9]  = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[10] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[11] = v(J,    1, NOP,  0, 0, 0, 0, 1, 0, 0);
    tv[12] = v(NOP,  0, BNE,  1, 0, 0, 0, 2, 0, 1);
    tv[13] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[14] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[15] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[16] = v(NOP,  0, BGTZ, 1, 0, 0, 0, 2, 0, 0);
    tv[17] = v(NOP,  0, BGTZ, 1, 0, 0, 1, 0, 1, 1);
    tv[18] = v(NOP,  0, BGTZ, 1, 0, 0, 1, 0, 1, 1);
    tv[19] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[20] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[21] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[22] = v(JALR, 1, NOP,  0, 0, 0, 1, 0, 0, 0);
    tv[23] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[24] = v(NOP,  0, BLEZ, 1, 0, 1, 0, 2, 0, 0);
    tv[25] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[26] = v(JR,   1, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[27] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[28] = v(NOP,  0, BLEZ, 1, 0, 0, 0, 0, 0, 0);
    tv[29] = v(NOP,  0, BGTZ, 1, 0, 1, 0, 0, 0, 0);
    tv[30] = v(J,    1, BEQ,  1, 1, 0, 0, 2, 0, 0);
    tv[31] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[32] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[33] = v(J,    0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[34] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[35] = v(JR,   1, NOP,  0, 0, 0, 0, 3, 0, 0);
    tv[36] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 1);
    tv[37] = v(NOP,  0, BEQ,  1, 1, 0, 0, 2, 1, 1);
    tv[38] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[39] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 1, 1);
    tv[40] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    tv[41] = v(NOP,  0, BNE,  1, 1, 0, 0, 0, 0, 0);
    tv[42] = v(NOP,  0, BEQ,  1, 1, 0, 1, 0, 0, 0);
    tv[43] = v(NOP,  0, NOP,  0, 0, 0, 0, 0, 0, 0);
    drive(v(NOP, 0, BEQ, 1, 1, 0, 0, 0, 0, 0));
    drive3(NOP, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst sel_pc comb", 32'(bus.sel_pc), 32'd2);
    chk("rst flush", 32'(bus.flush), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst3 flush", 32'(bus3.flush), 32'd0);
    drive(tv[0]);
    nrst = 1'b1;
    nrst3 = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(posedge clk);
      #1 drive(tv[i]);
      @(negedge clk);
      chk($sformatf("row%0d sel_pc", i), 32'(bus.sel_pc), 32'(tv[i].sel));
      chk($sformatf("row%0d flush", i), 32'(bus.flush), 32'(tv[i].fl));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(tv[i].bz));
    end
`ifdef REDIRECT_STATS_EN
    chk("dut br_taken_cnt", 32'(bus.br_taken_cnt), 32'd6);
    chk("dut jmp_cnt", 32'(bus.jmp_cnt), 32'd3);
`endif
    // Reset abort on the 3-cycle branch flush instance.
    @(posedge clk);
    #1 drive3(BEQ, 1'b1, 1'b1);
    @(negedge clk);
    chk("br3 sel_pc", 32'(bus3.sel_pc), 32'd2);
    @(posedge clk);
    #1 drive3(NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("br3 flush c1", 32'(bus3.flush), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("br3 flush c2", 32'(bus3.flush), 32'd1);
    #1 nrst3 = 1'b0;
    #1;
    chk("abort flush", 32'(bus3.flush), 32'd0);
    chk("abort busy", 32'(bus3.busy), 32'd0);
    @(negedge clk);
    nrst3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst flush %0d", i), 32'(bus3.flush), 32'd0);
      chk($sformatf("post-rst busy %0d", i), 32'(bus3.busy), 32'd0);
    end
`ifdef REDIRECT_STATS_EN
    chk("cnt3 after rst", 32'(bus3.br_taken_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 drive3(BEQ, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("invalid br cnt %0d", i), 32'(bus3.br_taken_cnt), 32'd0);
    end
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (i > 0) exp_cnt = exp_cnt == 15 ? 15 : exp_cnt + 1;
      #1 drive3(BEQ, 1'b1, 1'b1);
      @(negedge clk);
      chk($sformatf("sat cnt %0d", i), 32'(bus3.br_taken_cnt), 32'(exp_cnt));
    end
    @(posedge clk);
    #1 drive3(NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat cnt final", 32'(bus3.br_taken_cnt), 32'd15);
    chk("jmp3 cnt", 32'(bus3.jmp_cnt), 32'd0);
`else
    exp_cnt = 0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BR_FLUSH_CYCLES, 2, flush cycles after a taken EXE branch (legal 1..7).
- J_FLUSH_DELAY, 1, low cycles before a jump flush (legal 0..3).
- J_FLUSH_CYCLES, 1, flush cycles after a jump (legal 1..7).
- CNT_W, 16, statistics counter width (legal 4..32).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- nrst, in, 1, asynchronous active-low reset.
- ID_inst, in, 32, ID-stage instruction.
- ID_valid, in, 1, ID instruction is live (not a bubble).
- EXE_inst, in, 32, EXE-stage instruction.
- EXE_valid, in, 1, EXE instruction is live.
- zf, in, 1, ALU zero flag for EXE.
- nf, in, 1, ALU negative flag for EXE.
- stall, in, 1, pipeline freeze.
- sel_pc, out, 2, PC mux select: 0 PC+4, 1 jump, 2 branch, 3 register.
- flush, out, 1, registered flush of IF/ID.
- busy, out, 1, FSM not IDLE.

Function
REQ-003 An EXE branch SHALL be taken when EXE_valid is high and one of the following holds:
- BEQ (0x04) with zf=1.
- BNE (0x05) with zf=0.
- BLEZ (0x06) with zf|nf.
- BGTZ (0x07) with !zf&!nf.

REQ-004 An ID jump SHALL be one of the following, with ID_valid high:
- J or JAL (0x02/0x03), giving sel_pc=1.
- Opcode 0 with func JR (0x08) or JALR (0x09), giving sel_pc=3.

REQ-005 sel_pc SHALL be combinational, with the following priority:
- stall=1 gives 0.
- Otherwise a taken EXE branch gives 2.
- Otherwise an ID jump in IDLE gives 1 or 3.
- Otherwise 0.

REQ-006 The FSM SHALL have states IDLE, DELAY and FLUSH, plus a 3-bit down-counter cnt.

REQ-007 From IDLE, a taken branch SHALL go to FLUSH with cnt=BR_FLUSH_CYCLES.

REQ-008 From IDLE, an ID jump SHALL go as follows:
- If J_FLUSH_DELAY>0, to DELAY with cnt=J_FLUSH_DELAY.
- Otherwise to FLUSH with cnt=J_FLUSH_CYCLES.

REQ-009 DELAY SHALL decrement cnt; at cnt=1 it SHALL go to FLUSH with cnt=J_FLUSH_CYCLES.

REQ-010 FLUSH SHALL decrement cnt; at cnt=1 it SHALL return to IDLE.

REQ-011 A taken EXE branch in DELAY or FLUSH SHALL preempt the sequence: next state FLUSH, cnt=BR_FLUSH_CYCLES.

REQ-012 ID jumps seen outside IDLE SHALL be ignored; they are wrong-path instructions.

REQ-013 flush SHALL be a register, high exactly in the cycles after each edge that enters or stays in FLUSH.
- Branch detected in cycle N gives flush high in cycles N+1..N+BR_FLUSH_CYCLES.
- Jump detected in cycle N gives flush low for J_FLUSH_DELAY cycles, then high for J_FLUSH_CYCLES cycles.

REQ-014 While stall=1, the state, cnt, flush and the statistics counters SHALL hold their values.

REQ-015 busy SHALL equal (state != IDLE).

Reset
REQ-016 While nrst=0, the block SHALL hold state=IDLE, cnt=0, flush=0, busy=0 and statistics counters=0.
- sel_pc follows REQ-005 combinationally.

REQ-017 Reset asserted mid-sequence SHALL abort it immediately, with no residual flush after release.

Configuration
REQ-018 With macro REDIRECT_STATS_EN defined, the block SHALL add two outputs:
- br_taken_cnt [CNT_W-1:0], incremented on each non-stalled cycle with a taken branch.
- jmp_cnt [CNT_W-1:0], incremented on each accepted ID jump (REQ-008 transition).
- Both saturate at all-ones.

REQ-019 Without REDIRECT_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-020 A shared package pc_ctrl_pkg SHALL hold:
- Opcode and func constants.
- sel_pc encodings (SEL_PC4, SEL_JMP, SEL_BR, SEL_JR).
- The FSM state enum.

REQ-021 Saturating counters SHALL use a sub-module sat_counter, parametrised by width, with clk, nrst, en and count ports.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Defaults, EXE BEQ with zf=1 in cycle 5: sel_pc=2 in cycle 5, flush=1 in cycles 6 and 7, busy back to 0 after cycle 7.
- Defaults, ID JR in cycle 3: sel_pc=3 in cycle 3, flush=0 in cycle 4, flush=1 in cycle 5; a JAL in ID in cycle 4 is ignored.
- J in ID in cycle 3, then taken BNE (zf=0) in cycle 4: sel_pc=2 in cycle 4, flush=1 in cycles 5 and 6 (preemption).
- BGTZ with zf=0, nf=0 and stall=1 for cycles 5-6: sel_pc=0 while stalled; FSM frozen; flush pattern resumes after stall drops.
- BR_FLUSH_CYCLES=3 with nrst pulsed low in the second flush cycle: flush=0 at once and stays 0 after release.
- REDIRECT_STATS_EN with CNT_W=4 and 20 taken branches: br_taken_cnt saturates at 15; EXE_valid=0 branches do not count.
